freelist_rat_alloc: RTL and testbench

- Circular free list of physical register tags for the 2-wide OoO core.
- Dispatch side: hands out up to SCALAR_WIDTH tags per cycle and reports, for each tag, the free-list slot it came from. The rename/ROB path records tag and slot.
- Retire side: pushes freed (old) tags back at the tail.
- Rollback side: takes the recorded free-list slot of the oldest squashed instruction and rewinds the head pointer, reclaiming every tag allocated after it in one cycle.

---
 rtl/freelist_rat_alloc_pkg.sv | 37 +++
 rtl/freelist_rat_alloc_if.sv | 29 ++
 rtl/freelist_rat_alloc_ptr_calc.sv | 38 +++
 rtl/freelist_rat_alloc.sv | 109 ++++++++++
 tb/tb_freelist_rat_alloc.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/freelist_rat_alloc_pkg.sv
// ---------------------------------------------------------------------------
// fl_pkg: shared sizing, types and helpers for the physical-register free list.
//   SCALAR_WIDTH    dispatch/retire lanes per cycle
//   NUM_PR_ENTRIES  physical registers
//   NUM_AR_ENTRIES  architectural registers (tags 0..NUM_AR_ENTRIES-1 mapped at reset)
//   NUM_FL_ENTRIES  free-list slots
// ---------------------------------------------------------------------------
package fl_pkg;
    localparam int SCALAR_WIDTH   = 2;
    localparam int NUM_PR_ENTRIES = 64;
    localparam int NUM_AR_ENTRIES = 32;
    localparam int NUM_FL_ENTRIES = NUM_PR_ENTRIES - NUM_AR_ENTRIES;

    localparam int PR_W   = $clog2(NUM_PR_ENTRIES);
    localparam int FL_W   = $clog2(NUM_FL_ENTRIES);
    localparam int CNT_W  = FL_W + 1;
    localparam int FREE_W = $clog2(SCALAR_WIDTH) + 1;
    localparam int LANE_W = $clog2(SCALAR_WIDTH + 1);

    typedef logic [PR_W-1:0]   preg_idx_t;
    typedef logic [FL_W-1:0]   fl_idx_t;
    typedef logic [CNT_W-1:0]  fl_count_t;
    typedef logic [FREE_W-1:0] free_num_t;
    typedef logic [LANE_W-1:0] lane_cnt_t;

    function automatic lane_cnt_t popcount(input logic [SCALAR_WIDTH-1:0] v);
        lane_cnt_t n;
        n = '0;
        for (int i = 0; i < SCALAR_WIDTH; i++) n = n + lane_cnt_t'(v[i]);
        return n;
    endfunction

    // min(count, SCALAR_WIDTH)
    function automatic free_num_t clamp_free(input fl_count_t c);
        return (c >= fl_count_t'(SCALAR_WIDTH)) ? free_num_t'(SCALAR_WIDTH) : free_num_t'(c);
    endfunction
endpackage

// File: rtl/freelist_rat_alloc_if.sv
// ---------------------------------------------------------------------------
// freelist_rat_alloc_if: dispatch / retire / rollback bundle of the free list.
//   slave  : the free list (takes requests, drives tags and status)
//   master : the rename/retire logic driving it
// ---------------------------------------------------------------------------
interface freelist_rat_alloc_if;
    import fl_pkg::*;

    logic [SCALAR_WIDTH-1:0] dispatch_req;
    logic [SCALAR_WIDTH-1:0] retire_en;
    preg_idx_t               retire_T_idx [SCALAR_WIDTH];
    logic                    rollback_en;
    fl_idx_t                 FL_rollback_idx;
    preg_idx_t               T_idx [SCALAR_WIDTH];
    fl_idx_t                 FL_idx [SCALAR_WIDTH];
    logic [SCALAR_WIDTH-1:0] T_valid;
    free_num_t               free_num;
    logic                    fl_error;

    modport slave (
        input  dispatch_req, retire_en, retire_T_idx, rollback_en, FL_rollback_idx,
        output T_idx, FL_idx, T_valid, free_num, fl_error
    );

    modport master (
        output dispatch_req, retire_en, retire_T_idx, rollback_en, FL_rollback_idx,
        input  T_idx, FL_idx, T_valid, free_num, fl_error
    );
endinterface

// File: rtl/freelist_rat_alloc_ptr_calc.sv
// ---------------------------------------------------------------------------
// fl_ptr_calc: next-state head/tail/count of the circular free list.
//   head, tail, count    current pointers and occupancy
//   allocs, frees        tags handed out / returned this cycle
//   rollback_en/idx      rewind head to a recorded slot
//   head_next, tail_next, count_next
// Pointers wrap naturally at NUM_FL_ENTRIES (a power of two).
// ---------------------------------------------------------------------------
module fl_ptr_calc
    import fl_pkg::*;
(
    input  fl_idx_t   head,
    input  fl_idx_t   tail,
    input  fl_count_t count,
    input  lane_cnt_t allocs,
    input  lane_cnt_t frees,
    input  logic      rollback_en,
    input  fl_idx_t   rollback_idx,
    output fl_idx_t   head_next,
    output fl_idx_t   tail_next,
    output fl_count_t count_next
);
    fl_idx_t span;

    always_comb begin
        tail_next = tail + fl_idx_t'(frees);
        span      = tail_next - rollback_idx;
        if (rollback_en) begin
            // Everything from the rewound head up to the new tail is free again;
            // a zero span can only mean the whole ring is free.
            head_next  = rollback_idx;
            count_next = (span == '0) ? fl_count_t'(NUM_FL_ENTRIES) : fl_count_t'(span);
        end else begin
            head_next  = head + fl_idx_t'(allocs);
            count_next = count - fl_count_t'(allocs) + fl_count_t'(frees);
        end
    end
endmodule

// File: rtl/freelist_rat_alloc.sv
// ---------------------------------------------------------------------------
// freelist_rat_alloc: circular free list of physical register tags.
//   clock, reset  system clock, synchronous active-high reset
//   bus (slave)   dispatch_req/T_idx/FL_idx/T_valid : same-cycle allocation
//                 retire_en/retire_T_idx            : tags returned at tail
//                 rollback_en/FL_rollback_idx       : rewind head to a slot
//                 free_num                          : registered min(count, lanes)
//                 fl_error                          : sticky protocol error
// Optional build macro FREELIST_ERR_CHECK_EN enables fl_error checking;
// without it fl_error is tied low.
// ---------------------------------------------------------------------------
module freelist_rat_alloc
    import fl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    freelist_rat_alloc_if.slave bus
);
    preg_idx_t slots [NUM_FL_ENTRIES];
    fl_idx_t   head, tail, head_next, tail_next;
    fl_count_t count, count_next;
    free_num_t free_num_q;

    logic [SCALAR_WIDTH-1:0] t_valid;
    fl_idx_t                 rd_slot [SCALAR_WIDTH];
    fl_idx_t                 wr_slot [SCALAR_WIDTH];
    lane_cnt_t               allocs, frees;

    for (genvar w = 0; w < SCALAR_WIDTH; w++) begin : g_lane
        assign rd_slot[w]    = head + fl_idx_t'(w);
        assign bus.T_idx[w]  = slots[rd_slot[w]];
        assign bus.FL_idx[w] = rd_slot[w];
        assign t_valid[w]    = bus.dispatch_req[w] && (fl_count_t'(w) < count)
                               && !bus.rollback_en && !reset;
    end

    // Retiring lanes are packed at the tail in lane order.
    always_comb begin
        lane_cnt_t rank;
        rank = '0;
        for (int w = 0; w < SCALAR_WIDTH; w++) begin
            wr_slot[w] = tail + fl_idx_t'(rank);
            rank       = rank + lane_cnt_t'(bus.retire_en[w]);
        end
    end

    assign allocs       = popcount(t_valid);
    assign frees        = popcount(bus.retire_en);
    assign bus.T_valid  = t_valid;
    assign bus.free_num = free_num_q;

    fl_ptr_calc u_ptr_calc (
        .head        (head),
        .tail        (tail),
        .count       (count),
        .allocs      (allocs),
        .frees       (frees),
        .rollback_en (bus.rollback_en),
        .rollback_idx(bus.FL_rollback_idx),
        .head_next   (head_next),
        .tail_next   (tail_next),
        .count_next  (count_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FL_ENTRIES; i++) slots[i] <= preg_idx_t'(NUM_AR_ENTRIES + i);
            head       <= '0;
            tail       <= '0;
            count      <= fl_count_t'(NUM_FL_ENTRIES);
            free_num_q <= free_num_t'(SCALAR_WIDTH);
        end else begin
            for (int w = 0; w < SCALAR_WIDTH; w++) begin
                if (bus.retire_en[w]) slots[wr_slot[w]] <= bus.retire_T_idx[w];
            end
            head       <= head_next;
            tail       <= tail_next;
            count      <= count_next;
            free_num_q <= clamp_free(count_next);
        end
    end

`ifdef FREELIST_ERR_CHECK_EN
    logic                  err_q;
    logic                  overflow, lane_gap, rb_bad;
    logic [SCALAR_WIDTH:0] req_ext;
    fl_idx_t               rb_off;

    // Requests must be a contiguous run from lane 0: r & (r+1) == 0.
    assign req_ext  = {1'b0, bus.dispatch_req};
    assign lane_gap = |(req_ext & (req_ext + 1'b1));
    assign overflow = (frees != '0) &&
                      ((count + fl_count_t'(frees)) > fl_count_t'(NUM_FL_ENTRIES));
    // Allocated slots run from tail for (N - count) entries; head itself is
    // a legal target (nothing to reclaim).
    assign rb_off   = bus.FL_rollback_idx - tail;
    assign rb_bad   = bus.rollback_en &&
                      (fl_count_t'(rb_off) > (fl_count_t'(NUM_FL_ENTRIES) - count));

    always_ff @(posedge clock) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_q | overflow | lane_gap | rb_bad;
    end

    assign bus.fl_error = err_q;
`else
    assign bus.fl_error = 1'b0;
`endif
endmodule

// File: tb/tb_freelist_rat_alloc.sv
// ---------------------------------------------------------------------------
// tb_freelist_rat_alloc: directed + constrained-random bench for the free list.
// A reference model of the ring (slots/head/tail/count) produces expectations
// that go through a scoreboard queue and are compared at mid-cycle.
// ---------------------------------------------------------------------------
module tb_freelist_rat_alloc;
    import fl_pkg::*;

    localparam int N = NUM_FL_ENTRIES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    freelist_rat_alloc_if bus ();

    freelist_rat_alloc dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    typedef struct {
        string      tag;
        logic [5:0] t0, t1;
        logic [4:0] f0, f1;
        logic [1:0] tv, fn;
        logic       err;
        bit         full;
    } exp_t;

    typedef struct {
        logic [5:0] t0, t1;
        logic [4:0] f0, f1;
        logic [1:0] tv, fn;
        logic       err;
    } obs_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   m_slots [N];
    int   m_head, m_tail, m_count;
    logic m_err;
    bit   m_valid = 0;
    obs_t o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst_in, input logic [1:0] req,
                        input logic [1:0] ren, input int rt0, input int rt1,
                        input logic rb, input int rbi, output obs_t ob);
        exp_t e, p;
        int   allocs, frees, k, c;
        @(negedge clk);
        rst                 = rst_in;
        bus.dispatch_req    = req;
        bus.retire_en       = ren;
        bus.retire_T_idx[0] = 6'(rt0);
        bus.retire_T_idx[1] = 6'(rt1);
        bus.rollback_en     = rb;
        bus.FL_rollback_idx = 5'(rbi);
        e.tag  = tag;
        e.full = m_valid;
        for (int w = 0; w < 2; w++)
            e.tv[w] = req[w] && (w < m_count) && !rb && !rst_in;
        e.t0  = 6'(m_slots[m_head % N]);
        e.t1  = 6'(m_slots[(m_head + 1) % N]);
        e.f0  = 5'(m_head % N);
        e.f1  = 5'((m_head + 1) % N);
        e.fn  = (m_count >= 2) ? 2'd2 : 2'(m_count);
        e.err = m_err;
        sb.push_back(e);
        #1;
        ob.t0 = bus.T_idx[0];  ob.t1 = bus.T_idx[1];
        ob.f0 = bus.FL_idx[0]; ob.f1 = bus.FL_idx[1];
        ob.tv = bus.T_valid;   ob.fn = bus.free_num; ob.err = bus.fl_error;
        p = sb.pop_front();
        check({p.tag, "/T_valid"}, 32'(ob.tv), 32'(p.tv));
        if (p.full) begin
            check({p.tag, "/T_idx0"},   32'(ob.t0),  32'(p.t0));
            check({p.tag, "/T_idx1"},   32'(ob.t1),  32'(p.t1));
            check({p.tag, "/FL_idx0"},  32'(ob.f0),  32'(p.f0));
            check({p.tag, "/FL_idx1"},  32'(ob.f1),  32'(p.f1));
            check({p.tag, "/free_num"}, 32'(ob.fn),  32'(p.fn));
            check({p.tag, "/fl_error"}, 32'(ob.err), 32'(p.err));
        end
        @(posedge clk);
        if (rst_in) begin
            for (int i = 0; i < N; i++) m_slots[i] = NUM_AR_ENTRIES + i;
            m_head = 0; m_tail = 0; m_count = N; m_err = 1'b0; m_valid = 1;
        end else begin
            allocs = int'(e.tv[0]) + int'(e.tv[1]);
            frees  = int'(ren[0]) + int'(ren[1]);
`ifdef FREELIST_ERR_CHECK_EN
            if (frees > 0 && m_count + frees > N) m_err = 1'b1;
`endif
            k = 0;
            if (ren[0]) begin m_slots[(m_tail + k) % N] = rt0; k++; end
            if (ren[1]) begin m_slots[(m_tail + k) % N] = rt1; k++; end
            m_tail = (m_tail + frees) % N;
            if (rb) begin
                m_head  = rbi;
                c       = (m_tail - rbi + N) % N;
                m_count = (c == 0) ? N : c;
            end else begin
                m_head  = (m_head + allocs) % N;
                m_count = m_count - allocs + frees;
            end
        end
    endtask

    initial begin
        int r, nf, maxf, maxo, off;
        logic [1:0] req, ren;
        logic       rb;
        bus.dispatch_req = '0; bus.retire_en = '0; bus.rollback_en = 1'b0;
        bus.retire_T_idx[0] = '0; bus.retire_T_idx[1] = '0; bus.FL_rollback_idx = '0;

        // Reset; dispatch during reset must not allocate.
        step("reset0", 1, 2'b00, 2'b00, 0, 0, 0, 0, o);
        step("reset1", 1, 2'b11, 2'b00, 0, 0, 0, 0, o);

        // First dual allocation straight out of reset.
        step("alloc0", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        check("plan_first_T_idx0", 32'(o.t0), 32);
        check("plan_first_T_idx1", 32'(o.t1), 33);
        check("plan_first_FL_idx1", 32'(o.f1), 1);
        check("plan_first_T_valid", 32'(o.tv), 3);
        step("alloc1", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        check("plan_head2_T_idx0", 32'(o.t0), 34);
        check("plan_count30_free_num", 32'(o.fn), 2);
        for (int i = 2; i < 16; i++) step("drain", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);

        // Empty: no allocation, free_num 0; retire is not bypassed.
        step("empty", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        check("plan_empty_T_valid", 32'(o.tv), 0);
        check("plan_empty_free_num", 32'(o.fn), 0);
        step("retire_empty", 0, 2'b11, 2'b11, 5, 9, 0, 0, o);
        check("plan_no_bypass_T_valid", 32'(o.tv), 0);
        step("after_retire", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        check("plan_reuse_T_idx0", 32'(o.t0), 5);
        check("plan_reuse_T_idx1", 32'(o.t1), 9);
        check("plan_reuse_FL_idx1", 32'(o.f1), 1);
        check("plan_reuse_T_valid", 32'(o.tv), 3);

        // Rollback from head=6 to slot 2.
        step("reset2", 1, 2'b00, 2'b00, 0, 0, 0, 0, o);
        for (int i = 0; i < 3; i++) step("pre_rb", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        step("rollback", 0, 2'b11, 2'b00, 0, 0, 1, 2, o);
        check("plan_rb_T_valid", 32'(o.tv), 0);
        step("after_rb", 0, 2'b01, 2'b00, 0, 0, 0, 0, o);
        check("plan_rb_T_idx0", 32'(o.t0), 34);
        check("plan_rb_FL_idx0", 32'(o.f0), 2);
        check("plan_rb_T_valid", 32'(o.tv), 1);

        // Rollback onto the post-retire tail: list becomes full.
        step("reset3", 1, 2'b00, 2'b00, 0, 0, 0, 0, o);
        step("pre_full0", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        step("pre_full1", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        step("rb_full", 0, 2'b00, 2'b01, 40, 0, 1, 1, o);
        step("after_full", 0, 2'b00, 2'b00, 0, 0, 0, 0, o);
        check("plan_full_free_num", 32'(o.fn), 2);
        check("plan_full_fl_error", 32'(o.err), 0);
        for (int i = 0; i < 15; i++) step("refill", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        step("refill_last", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        check("plan_full_last_T_valid", 32'(o.tv), 3);
        check("plan_full_wrap_T_idx1", 32'(o.t1), 40);
        step("refill_empty", 0, 2'b11, 2'b00, 0, 0, 0, 0, o);
        check("plan_full_then_empty", 32'(o.tv), 0);

        // Constrained-random legal traffic against the model.
        step("reset4", 1, 2'b00, 2'b00, 0, 0, 0, 0, o);
        for (int i = 0; i < 300; i++) begin
            r   = $urandom_range(0, 2);
            req = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            maxf = (N - m_count < 2) ? N - m_count : 2;
            nf  = $urandom_range(0, maxf);
            ren = (nf == 0) ? 2'b00 : (nf == 2) ? 2'b11 : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
            rb  = ($urandom_range(0, 7) == 0);
            maxo = (N - m_count > N - 1) ? N - 1 : N - m_count;
            off = 0;
            if (rb && maxo >= nf) off = $urandom_range(nf, maxo);
            else rb = 1'b0;
            step("rand", 0, req, ren, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 rb, (m_tail + off) % N, o);
        end

`ifdef FREELIST_ERR_CHECK_EN
        step("reset5", 1, 2'b00, 2'b00, 0, 0, 0, 0, o);
        step("overflow", 0, 2'b00, 2'b01, 7, 0, 0, 0, o);
        check("plan_err_before", 32'(o.err), 0);
        step("err_set", 0, 2'b00, 2'b00, 0, 0, 0, 0, o);
        check("plan_err_set", 32'(o.err), 1);
        step("err_hold", 0, 2'b00, 2'b00, 0, 0, 0, 0, o);
        check("plan_err_hold", 32'(o.err), 1);
        step("reset6", 1, 2'b00, 2'b00, 0, 0, 0, 0, o);
        step("err_clear", 0, 2'b00, 2'b00, 0, 0, 0, 0, o);
        check("plan_err_cleared", 32'(o.err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
